uart_rx: RTL

UART receiver that samples the serial rx line at 16x the bit rate and recovers 8N1 frames. It uses the same 2-bit baud_rate encoding as the TX-side baud generator, so both ends of a link share one rate select. Recovered bytes are presented on a valid/ready holding register to the host logic, with framing and overrun flags.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, 8N1, valid/ready holding register.
// Define PARITY_EN to receive 8 data bits plus one even-parity bit.
module uart_rx (
    input  logic       clock,
    input  logic       rst,
    input  logic [1:0] baud_rate,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [7:0] DIV_2400  = 8'd163;
    localparam logic [7:0] DIV_4800  = 8'd81;
    localparam logic [7:0] DIV_9600  = 8'd41;
    localparam logic [7:0] DIV_19200 = 8'd20;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rxs;
    logic [7:0] div_sel;
    logic [7:0] div_cnt;
    logic [3:0] samp;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       par_bad;
    logic       tick;
    logic       sample;

    function automatic logic [7:0] div_of(input logic [1:0] sel);
        logic [7:0] d;
        case (sel)
            2'b00:   d = DIV_2400;
            2'b01:   d = DIV_4800;
            2'b11:   d = DIV_19200;
            default: d = DIV_9600;
        endcase
        return d;
    endfunction

    assign tick   = (div_cnt == div_sel - 8'd1);
    assign sample = tick && (samp == 4'd7);
    assign busy   = (state != IDLE);

`ifndef PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM with tick/sample counters and the output holding register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_sel   <= DIV_9600;
            div_cnt   <= '0;
            samp      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_bad   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (state != IDLE) begin
                if (tick) begin
                    div_cnt <= '0;
                    samp    <= samp + 4'd1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        div_cnt <= '0;
                        samp    <= '0;
                        div_sel <= div_of(baud_rate);
                    end
                end
                START: begin
                    if (sample) begin
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                        state   <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (sample) begin
                        par_bad    <= (rxs != ^shift);
                        parity_err <= (rxs != ^shift);
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            state <= IDLE;
                            if (!par_bad) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end
                    end
                end
                BREAK: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
